// File: rtl/fp_issue_select_if.sv
// fp_issue_select_if: issue-request handshake between the FP reservation station and the issue selector
`ifndef RS_FPU_LEN
`define SPEC_STATES 4
`define RS_FPU_LEN 32
`define RS_VALID 0
`define RS_KILLMASK `SPEC_STATES:1
`define RS_FPU_FUCLASS (`SPEC_STATES+2):(`SPEC_STATES+1)
`endif

interface fp_issue_select_if #(
    parameter int NREQ      = 2,
    parameter int ENTRY_LEN = `RS_FPU_LEN
);
    logic [NREQ*ENTRY_LEN-1:0] IssueReq_Entries;
    logic [NREQ-1:0]           IssueReq_Valid;
    logic [NREQ-1:0]           Issued_Valid;

    modport master (output IssueReq_Entries, output IssueReq_Valid, input Issued_Valid);
    modport slave  (input IssueReq_Entries, input IssueReq_Valid, output Issued_Valid);
endinterface

// File: rtl/fp_issue_select.sv
// fp_issue_select: binds oldest-first RS issue requests to the two FP ports and tracks the iterative divider
`ifndef RS_FPU_LEN
`define SPEC_STATES 4
`define RS_FPU_LEN 32
`define RS_VALID 0
`define RS_KILLMASK `SPEC_STATES:1
`define RS_FPU_FUCLASS (`SPEC_STATES+2):(`SPEC_STATES+1)
`endif

module fp_issue_select #(
    parameter int NREQ      = 2,
    parameter int ENTRY_LEN = `RS_FPU_LEN,
    parameter int SPEC_W    = `SPEC_STATES,
    parameter int DIV_LAT   = 12,
    parameter int SQRT_LAT  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 Kill_Enable,
    input  logic                 Update_KillMask,
    input  logic [SPEC_W-1:0]    FUBR_SpecTag,
    fp_issue_select_if.slave     rs,
    output logic [ENTRY_LEN-1:0] P0_Uop,
    output logic                 P0_Valid,
    output logic [ENTRY_LEN-1:0] P1_Uop,
    output logic                 P1_Valid,
    output logic                 Div_Busy
);
    localparam int MAX_LAT = DIV_LAT > SQRT_LAT ? DIV_LAT : SQRT_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);

    logic [CW-1:0]        div_cnt;
    logic [SPEC_W-1:0]    div_km;
    logic [SPEC_W-1:0]    clr_mask;
    logic [ENTRY_LEN-1:0] cur, g0_uop, g1_uop;
    logic [1:0]           cls, g1_cls;
    logic                 elig, g0, g1;
    logic [NREQ-1:0]      grant;

    assign clr_mask = Update_KillMask ? FUBR_SpecTag : '0;

    function automatic logic [ENTRY_LEN-1:0] upd(input logic [ENTRY_LEN-1:0] e, input logic [SPEC_W-1:0] m);
        upd = e;
        upd[`RS_KILLMASK] = e[`RS_KILLMASK] & ~m;
    endfunction

    function automatic logic hit(input logic [ENTRY_LEN-1:0] e, input logic en, input logic [SPEC_W-1:0] tag);
        hit = en && |(e[`RS_KILLMASK] & tag);
    endfunction

    // Oldest-first scan; each port taken at most once, younger slots may bypass blocked older ones
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        g0_uop = '0;
        g1_uop = '0;
        g1_cls = '0;
        grant = '0;
        cur = '0;
        cls = '0;
        elig = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            cur = rs.IssueReq_Entries[i*ENTRY_LEN +: ENTRY_LEN];
            cls = cur[`RS_FPU_FUCLASS];
            elig = rs.IssueReq_Valid[i] && !hit(cur, Kill_Enable, FUBR_SpecTag);
            if (elig && cls == 2'd0 && !g0) begin
                g0 = 1'b1;
                g0_uop = cur;
                grant[i] = 1'b1;
            end else if (elig && cls != 2'd0 && !g1 &&
                         (cls == 2'd3 ? div_cnt != CW'(1) : div_cnt == '0)) begin
                g1 = 1'b1;
                g1_uop = cur;
                g1_cls = cls;
                grant[i] = 1'b1;
            end
        end
    end

    assign rs.Issued_Valid = (Stall || Flush || rst) ? '0 : grant;
    assign Div_Busy = div_cnt != '0;

    // Port issue latches: load on free-running edges, hold under Stall while still honouring kill/update
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            P0_Valid <= 1'b0;
            P1_Valid <= 1'b0;
            P0_Uop <= '0;
            P1_Uop <= '0;
        end else if (Stall) begin
            P0_Valid <= P0_Valid && !hit(P0_Uop, Kill_Enable, FUBR_SpecTag);
            P1_Valid <= P1_Valid && !hit(P1_Uop, Kill_Enable, FUBR_SpecTag);
            P0_Uop <= upd(P0_Uop, clr_mask);
            P1_Uop <= upd(P1_Uop, clr_mask);
        end else begin
            P0_Valid <= g0;
            P1_Valid <= g1;
            P0_Uop <= upd(g0 ? g0_uop : P0_Uop, clr_mask);
            P1_Uop <= upd(g1 ? g1_uop : P1_Uop, clr_mask);
        end
    end

    // Divider occupancy: loads on a granted FDIV/FSQRT, runs free otherwise, aborts when its uop is killed
    always_ff @(posedge clk) begin
        if (rst || Flush) begin
            div_cnt <= '0;
            div_km <= '0;
        end else if (!Stall && g1 && g1_cls != 2'd3) begin
            div_cnt <= g1_cls == 2'd1 ? CW'(DIV_LAT) : CW'(SQRT_LAT);
            div_km <= g1_uop[`RS_KILLMASK] & ~clr_mask;
        end else if (Kill_Enable && |(div_km & FUBR_SpecTag)) begin
            div_cnt <= '0;
            div_km <= '0;
        end else begin
            div_cnt <= div_cnt != '0 ? div_cnt - CW'(1) : div_cnt;
            div_km <= div_km & ~clr_mask;
        end
    end
endmodule

// File: tb/tb_fp_issue_select.sv
// tb_fp_issue_select: directed scenario checks of the FP issue selector
`ifndef RS_FPU_LEN
`define SPEC_STATES 4
`define RS_FPU_LEN 32
`define RS_VALID 0
`define RS_KILLMASK `SPEC_STATES:1
`define RS_FPU_FUCLASS (`SPEC_STATES+2):(`SPEC_STATES+1)
`endif

module tb_fp_issue_select;
    logic clk = 1'b0, rst, Stall, Flush, Kill_Enable, Update_KillMask;
    logic [3:0] FUBR_SpecTag;
    logic [31:0] P0_Uop, P1_Uop;
    logic P0_Valid, P1_Valid, Div_Busy;
    int n_cmp = 0, n_err = 0;

    fp_issue_select_if #(.NREQ(2), .ENTRY_LEN(32)) bus ();

    fp_issue_select #(.NREQ(2), .ENTRY_LEN(32), .SPEC_W(4), .DIV_LAT(12), .SQRT_LAT(16)) dut (
        .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .Kill_Enable(Kill_Enable),
        .Update_KillMask(Update_KillMask), .FUBR_SpecTag(FUBR_SpecTag), .rs(bus.slave),
        .P0_Uop(P0_Uop), .P0_Valid(P0_Valid), .P1_Uop(P1_Uop), .P1_Valid(P1_Valid), .Div_Busy(Div_Busy)
    );

    always #5 clk = ~clk;

    // entry layout: [0] valid, [4:1] killmask, [6:5] class, [31:7] payload
    function automatic logic [31:0] mk(input logic [1:0] c, input logic [3:0] km, input logic [24:0] pay);
        mk = {pay, c, km, 1'b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] v);
        bus.IssueReq_Entries = {e1, e0};
        bus.IssueReq_Valid = v;
    endtask

    task automatic test_reset();
        rst = 1'b1; Stall = 0; Flush = 0; Kill_Enable = 0; Update_KillMask = 0; FUBR_SpecTag = 0;
        req(mk(0, 0, 1), mk(3, 0, 2), 2'b11);
        step();
        step();
        n_cmp++;
        if (bus.Issued_Valid !== 2'b00) begin n_err++; $display("FAIL reset_issued got %b exp 00", bus.Issued_Valid); end
        n_cmp++;
        if ({P0_Valid, P1_Valid, Div_Busy} !== 3'b000) begin n_err++; $display("FAIL reset_valids got %b exp 000", {P0_Valid, P1_Valid, Div_Busy}); end
        n_cmp++;
        if ({P0_Uop, P1_Uop} !== 64'h0) begin n_err++; $display("FAIL reset_uops got %h exp 0", {P0_Uop, P1_Uop}); end
        req(0, 0, 2'b00);
        rst = 1'b0;
        step();
    endtask

    task automatic test_dual();
        logic [31:0] e0, e1;
        e0 = mk(0, 4'b0001, 25'h11);
        e1 = mk(3, 4'b0100, 25'h22);
        req(e0, e1, 2'b11);
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b11) begin n_err++; $display("FAIL dual_issued got %b exp 11", bus.Issued_Valid); end
        step();
        req(0, 0, 2'b00);
        n_cmp++;
        if ({P0_Valid, P1_Valid} !== 2'b11 || P0_Uop !== e0 || P1_Uop !== e1) begin
            n_err++; $display("FAIL dual_latch got %b %h %h exp 11 %h %h", {P0_Valid, P1_Valid}, P0_Uop, P1_Uop, e0, e1);
        end
        step();
        n_cmp++;
        if ({P0_Valid, P1_Valid} !== 2'b00) begin n_err++; $display("FAIL dual_drain got %b exp 00", {P0_Valid, P1_Valid}); end
    endtask

    task automatic test_two_fma();
        logic [31:0] e0, e1;
        e0 = mk(0, 4'b0001, 25'h33);
        e1 = mk(0, 4'b0000, 25'h44);
        req(e0, e1, 2'b11);
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b01) begin n_err++; $display("FAIL two_fma_issued got %b exp 01", bus.Issued_Valid); end
        step();
        n_cmp++;
        if (P0_Valid !== 1'b1 || P0_Uop !== e0 || P1_Valid !== 1'b0) begin
            n_err++; $display("FAIL two_fma_latch got %b %h %b exp 1 %h 0", P0_Valid, P0_Uop, P1_Valid, e0);
        end
        Kill_Enable = 1'b1; FUBR_SpecTag = 4'b0001;
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b10) begin n_err++; $display("FAIL dying_slot got %b exp 10", bus.Issued_Valid); end
        Kill_Enable = 1'b0; FUBR_SpecTag = 0;
        req(0, 0, 2'b00);
        step();
    endtask

    task automatic test_div();
        req(mk(1, 0, 25'h55), 0, 2'b01);
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b01) begin n_err++; $display("FAIL div_first got %b exp 01", bus.Issued_Valid); end
        step();
        req(mk(1, 0, 25'h66), mk(3, 0, 25'h77), 2'b11);
        for (int k = 0; k < 12; k++) begin
            #1;
            n_cmp++;
            if (Div_Busy !== 1'b1) begin n_err++; $display("FAIL div_busy k=%0d got %b exp 1", k, Div_Busy); end
            n_cmp++;
            if (bus.Issued_Valid !== (k == 11 ? 2'b00 : 2'b10)) begin
                n_err++; $display("FAIL div_block k=%0d got %b exp %b", k, bus.Issued_Valid, (k == 11 ? 2'b00 : 2'b10));
            end
            step();
        end
        #1;
        n_cmp++;
        if (Div_Busy !== 1'b0) begin n_err++; $display("FAIL div_done got %b exp 0", Div_Busy); end
        n_cmp++;
        if (bus.Issued_Valid !== 2'b01) begin n_err++; $display("FAIL div_regrant got %b exp 01", bus.Issued_Valid); end
        req(0, 0, 2'b00);
        step();
    endtask

    task automatic test_rst_mid();
        req(mk(1, 0, 25'h88), 0, 2'b01);
        step();
        req(0, 0, 2'b00);
        for (int k = 0; k < 7; k++) step();
        n_cmp++;
        if (Div_Busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy got %b exp 1", Div_Busy); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++;
        if ({P0_Valid, P1_Valid, Div_Busy} !== 3'b000 || {P0_Uop, P1_Uop} !== 64'h0) begin
            n_err++; $display("FAIL rst_mid got %b %h exp 000 0", {P0_Valid, P1_Valid, Div_Busy}, {P0_Uop, P1_Uop});
        end
    endtask

    task automatic test_flush_stall();
        req(mk(1, 0, 25'h99), mk(0, 0, 25'haa), 2'b11);
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b11) begin n_err++; $display("FAIL fs_issue got %b exp 11", bus.Issued_Valid); end
        step();
        n_cmp++;
        if ({P0_Valid, P1_Valid, Div_Busy} !== 3'b111) begin n_err++; $display("FAIL fs_pre got %b exp 111", {P0_Valid, P1_Valid, Div_Busy}); end
        Flush = 1'b1; Stall = 1'b1;
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b00) begin n_err++; $display("FAIL fs_issued got %b exp 00", bus.Issued_Valid); end
        step();
        Flush = 1'b0; Stall = 1'b0;
        req(0, 0, 2'b00);
        n_cmp++;
        if ({P0_Valid, P1_Valid, Div_Busy} !== 3'b000 || {P0_Uop, P1_Uop} !== 64'h0) begin
            n_err++; $display("FAIL fs_clear got %b %h exp 000 0", {P0_Valid, P1_Valid, Div_Busy}, {P0_Uop, P1_Uop});
        end
    endtask

    task automatic test_sqrt_kill();
        req(mk(2, 4'b0010, 25'hbb), 0, 2'b01);
        step();
        req(0, 0, 2'b00);
        Kill_Enable = 1'b1; FUBR_SpecTag = 4'b0010;
        step();
        Kill_Enable = 1'b0; FUBR_SpecTag = 0;
        n_cmp++;
        if (Div_Busy !== 1'b0) begin n_err++; $display("FAIL sqrt_kill_busy got %b exp 0", Div_Busy); end
        req(mk(1, 0, 25'hcc), 0, 2'b01);
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b01) begin n_err++; $display("FAIL sqrt_kill_regrant got %b exp 01", bus.Issued_Valid); end
        req(0, 0, 2'b00);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_update();
        req(mk(2, 4'b0010, 25'hdd), 0, 2'b01);
        step();
        req(mk(0, 4'b0110, 25'hee), 0, 2'b01);
        Update_KillMask = 1'b1; FUBR_SpecTag = 4'b0010;
        step();
        Update_KillMask = 1'b0;
        req(0, 0, 2'b00);
        n_cmp++;
        if (P0_Uop !== mk(0, 4'b0100, 25'hee)) begin n_err++; $display("FAIL upd_capture got %h exp %h", P0_Uop, mk(0, 4'b0100, 25'hee)); end
        Kill_Enable = 1'b1;
        step();
        Kill_Enable = 1'b0; FUBR_SpecTag = 0;
        n_cmp++;
        if (Div_Busy !== 1'b1) begin n_err++; $display("FAIL upd_survive got %b exp 1", Div_Busy); end
        for (int k = 0; k < 13; k++) step();
        n_cmp++;
        if (Div_Busy !== 1'b1) begin n_err++; $display("FAIL upd_count_last got %b exp 1", Div_Busy); end
        step();
        n_cmp++;
        if (Div_Busy !== 1'b0) begin n_err++; $display("FAIL upd_count_end got %b exp 0", Div_Busy); end
    endtask

    task automatic test_stall();
        logic [31:0] e0, e1;
        e0 = mk(0, 4'b0001, 25'h101);
        e1 = mk(3, 4'b0000, 25'h202);
        req(e0, e1, 2'b11);
        step();
        req(mk(0, 0, 25'h303), mk(3, 0, 25'h404), 2'b11);
        Stall = 1'b1;
        #1;
        n_cmp++;
        if (bus.Issued_Valid !== 2'b00) begin n_err++; $display("FAIL stall_issued got %b exp 00", bus.Issued_Valid); end
        step();
        n_cmp++;
        if ({P0_Valid, P1_Valid} !== 2'b11 || P0_Uop !== e0 || P1_Uop !== e1) begin
            n_err++; $display("FAIL stall_hold got %b %h %h exp 11 %h %h", {P0_Valid, P1_Valid}, P0_Uop, P1_Uop, e0, e1);
        end
        Kill_Enable = 1'b1; FUBR_SpecTag = 4'b0001;
        step();
        n_cmp++;
        if ({P0_Valid, P1_Valid} !== 2'b01) begin n_err++; $display("FAIL stall_kill got %b exp 01", {P0_Valid, P1_Valid}); end
        Kill_Enable = 1'b0; FUBR_SpecTag = 0; Stall = 1'b0;
        req(0, 0, 2'b00);
        step();
    endtask

    initial begin
        test_reset();
        test_dual();
        test_two_fma();
        test_div();
        test_rst_mid();
        test_flush_stall();
        test_sqrt_kill();
        test_update();
        test_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
